// File: rtl/uart_command_decoder.sv
// Parses opcode/operand byte streams from the UART receiver and drives
// framebuffer pixel writes (single pixel or run-length fill) over valid/ready.
module uart_command_decoder #(
    parameter int BITS_PER_PIXEL    = 3,
    parameter int FRAMEBUFFER_DEPTH = 640*480,
    parameter int ADDR_WIDTH        = 19,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic                      i_Rx_DV,
    input  logic [7:0]                i_Rx_Byte,
    output logic                      o_Wr_Valid,
    output logic [ADDR_WIDTH-1:0]     o_Wr_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Wr_Data,
    input  logic                      i_Wr_Ready,
    output logic                      o_Busy,
    output logic                      o_Overrun,
    output logic                      o_Error,
    output logic [1:0]                o_Error_Code
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0]     IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [23:0]           DEPTH_FIELD = 24'(FRAMEBUFFER_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(FRAMEBUFFER_DEPTH - 1);

    typedef enum logic [2:0] {
        S_OPCODE,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_FILL
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                is_fill;
    logic [1:0]          byte_idx;
    logic [23:0]         addr_field;
    logic [23:0]         count_field;
    logic [23:0]         remaining;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                in_operands;
    logic                timeout;
    logic                transfer;
    logic                fill_last;
    logic                accept_data;
    logic                err_fire;
    logic [1:0]          err_code;

    assign o_Busy      = (state == S_WRITE) || (state == S_FILL);
    assign in_operands = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA);
    assign timeout     = in_operands && !i_Rx_DV && (idle_cnt == IDLE_LAST);
    assign transfer    = o_Wr_Valid && i_Wr_Ready;
    // A fill ends on its last requested beat or at the final framebuffer pixel.
    assign fill_last   = (remaining == 24'd1) || (o_Wr_Addr == LAST_ADDR);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state <= S_OPCODE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept_data = 1'b0;
        err_fire    = 1'b0;
        err_code    = 2'd0;
        case (state)
            S_OPCODE: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == 8'h01 || i_Rx_Byte == 8'h02) begin
                        state_next = S_ADDR;
                    end else if (i_Rx_Byte != 8'h00) begin
                        err_fire = 1'b1;
                        err_code = 2'd1;
                    end
                end
            end
            S_ADDR: begin
                if (i_Rx_DV && byte_idx == 2'd2) begin
                    state_next = is_fill ? S_COUNT : S_DATA;
                end else if (timeout) begin
                    state_next = S_OPCODE;
                    err_fire   = 1'b1;
                    err_code   = 2'd3;
                end
            end
            S_COUNT: begin
                if (i_Rx_DV && byte_idx == 2'd2) begin
                    state_next = S_DATA;
                end else if (timeout) begin
                    state_next = S_OPCODE;
                    err_fire   = 1'b1;
                    err_code   = 2'd3;
                end
            end
            S_DATA: begin
                if (i_Rx_DV) begin
                    if (addr_field >= DEPTH_FIELD) begin
                        state_next = S_OPCODE;
                        err_fire   = 1'b1;
                        err_code   = 2'd2;
                    end else if (!is_fill) begin
                        state_next  = S_WRITE;
                        accept_data = 1'b1;
                    end else if (count_field == 24'd0) begin
                        state_next = S_OPCODE;
                    end else begin
                        state_next  = S_FILL;
                        accept_data = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = S_OPCODE;
                    err_fire   = 1'b1;
                    err_code   = 2'd3;
                end
            end
            S_WRITE: begin
                if (transfer) begin
                    state_next = S_OPCODE;
                end
            end
            S_FILL: begin
                if (transfer && fill_last) begin
                    state_next = S_OPCODE;
                end
            end
            default: state_next = S_OPCODE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            is_fill      <= 1'b0;
            byte_idx     <= 2'd0;
            addr_field   <= 24'd0;
            count_field  <= 24'd0;
            remaining    <= 24'd0;
            idle_cnt     <= '0;
            o_Wr_Valid   <= 1'b0;
            o_Wr_Addr    <= '0;
            o_Wr_Data    <= '0;
            o_Overrun    <= 1'b0;
            o_Error      <= 1'b0;
            o_Error_Code <= 2'd0;
        end else begin
            o_Error   <= err_fire;
            o_Overrun <= i_Rx_DV && o_Busy;
            if (err_fire) begin
                o_Error_Code <= err_code;
            end

            if (state_next != state || !in_operands || i_Rx_DV) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            if (state_next != state) begin
                byte_idx <= 2'd0;
            end else if (i_Rx_DV && (state == S_ADDR || state == S_COUNT)) begin
                byte_idx <= byte_idx + 2'd1;
            end

            if (state == S_OPCODE && i_Rx_DV) begin
                is_fill <= (i_Rx_Byte == 8'h02);
            end
            // Three big-endian bytes shift fully through the 24-bit field.
            if (state == S_ADDR && i_Rx_DV) begin
                addr_field <= {addr_field[15:0], i_Rx_Byte};
            end
            if (state == S_COUNT && i_Rx_DV) begin
                count_field <= {count_field[15:0], i_Rx_Byte};
            end

            if (accept_data) begin
                o_Wr_Valid <= 1'b1;
                o_Wr_Addr  <= addr_field[ADDR_WIDTH-1:0];
                o_Wr_Data  <= i_Rx_Byte[BITS_PER_PIXEL-1:0];
                remaining  <= count_field;
            end else if (transfer) begin
                if (state == S_WRITE || fill_last) begin
                    o_Wr_Valid <= 1'b0;
                end else begin
                    o_Wr_Addr <= o_Wr_Addr + ADDR_WIDTH'(1);
                    remaining <= remaining - 24'd1;
                end
            end
        end
    end

endmodule

// File: doc/uart_command_decoder.md
# uart_command_decoder

Byte-stream command decoder between the UART receiver and the framebuffer write port. Parses a one-byte opcode plus a fixed, opcode-dependent operand sequence from the receive stream, then issues framebuffer pixel writes over a valid/ready handshake. Supports single-pixel writes, run-length fills and no-ops. Reports malformed, out-of-range and stalled commands through an error strobe.

## Interface
- BITS_PER_PIXEL, 3, pixel data width; low bits of the data byte are used.
- FRAMEBUFFER_DEPTH, 640*480, number of addressable pixels; valid addresses are 0..DEPTH-1.
- ADDR_WIDTH, 19, write address width; must satisfy 2^ADDR_WIDTH >= FRAMEBUFFER_DEPTH.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles allowed between operand bytes.
- i_Clock  in  1  single clock; all logic on its rising edge.
- i_Reset_n  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  one-cycle strobe; i_Rx_Byte is valid this cycle.
- i_Rx_Byte  in  8  received byte.
- o_Wr_Valid  out  1  write request.
- o_Wr_Addr  out  ADDR_WIDTH  pixel address.
- o_Wr_Data  out  BITS_PER_PIXEL  pixel value.
- i_Wr_Ready  in  1  framebuffer accepts the write when high together with o_Wr_Valid.
- o_Busy  out  1  high while a write or fill is in flight; received bytes are not parsed.
- o_Overrun  out  1  one-cycle pulse when a byte arrives while o_Busy is high; that byte is dropped.
- o_Error  out  1  one-cycle pulse when a command is aborted.
- o_Error_Code  out  2  1=unknown opcode, 2=address out of range, 3=timeout; held until the next error.

## Operation
- Bytes are consumed only on cycles with i_Rx_DV=1. Multi-byte fields are big-endian.
- Opcodes:
  - 0x00 NOP: no operands.
  - 0x01 WRITE_PIXEL: 3 address bytes, then 1 data byte.
  - 0x02 FILL: 3 address bytes, then 3 count bytes, then 1 data byte.
  - Any other value: error code 1. State stays in S_OPCODE.
- States:
  - S_OPCODE: waits for the opcode byte.
  - S_ADDR: 3 bytes.
  - S_COUNT: 3 bytes, FILL only.
  - S_DATA: 1 byte.
  - S_WRITE: issues one write.
  - S_FILL: issues repeated writes.
- The operand byte index is an internal 2-bit counter, cleared on each state entry.
- Address check:
  - Performed when the data byte is received.
  - The 24-bit address field is compared against FRAMEBUFFER_DEPTH.
  - If address >= DEPTH: error code 2, no write, return to S_OPCODE.
- After the data byte:
  - WRITE_PIXEL enters S_WRITE.
  - FILL enters S_FILL. If count=0, FILL returns straight to S_OPCODE with no write and no error.
- S_FILL:
  - Writes data to addresses start, start+1, …
  - Stops after count writes or after writing DEPTH-1, whichever comes first.
  - Truncation at the end of the framebuffer is not an error.
- Timeout:
  - An idle counter is reset on every accepted byte and runs in S_ADDR, S_COUNT and S_DATA.
  - Reaching TIMEOUT_CYCLES gives error code 3 and a return to S_OPCODE; partial operands are discarded.
- o_Busy=1 exactly in S_WRITE and S_FILL.

## Timing
- Reset values:
  - o_Wr_Valid=0, o_Wr_Addr=0, o_Wr_Data=0.
  - o_Busy=0, o_Overrun=0, o_Error=0, o_Error_Code=0.
  - State=S_OPCODE; all counters 0.
- State changes occur on the rising edge of the cycle carrying i_Rx_DV.
- o_Wr_Valid rises in the cycle after the final data byte's i_Rx_DV cycle.
- Handshake:
  - o_Wr_Addr and o_Wr_Data are stable while o_Wr_Valid=1 and i_Wr_Ready=0.
  - A transfer happens on an edge where Valid=1 and Ready=1.
- Fill throughput is one write per cycle while i_Wr_Ready=1. o_Wr_Valid does not drop between fill beats.
- After the final transfer, o_Wr_Valid and o_Busy are 0 in the next cycle, and the next opcode byte is accepted from that cycle on.
- o_Error and o_Overrun are single-cycle pulses, registered one cycle after the triggering edge.
- Reset asserted mid-operation:
  - Outputs clear immediately (asynchronously); any in-flight write is abandoned.
  - After release, the decoder waits for an opcode.

## Test plan
- Bytes 01 00 00 05 07 with Ready=1 -> exactly one transfer, Addr=5, Data=7. Valid is high for 1 cycle, one cycle after the last byte.
- Bytes 02 00 00 0A 00 00 03 02 with Ready=1 -> three consecutive transfers to addresses 10, 11, 12, Data=2. o_Busy is high for 3 cycles.
- FILL at start=307198, count=5 -> two writes (307198, 307199), then idle with no error. FILL with count=0 -> no write.
- Opcode 0x09 -> o_Error pulse, code 1. Then 01 04 B0 00 01 (address 307200) -> code 2, no write. A following valid WRITE_PIXEL succeeds.
- Send 01 00, then wait TIMEOUT_CYCLES -> error code 3. A new 01 00 00 01 03 writes Addr=1, Data=3.
- Hold Ready=0 during a fill for 10 cycles while one byte arrives -> Addr and Data hold stable, o_Overrun pulses once. Assert reset mid-fill -> all outputs are 0 asynchronously.
